uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_baud_tick.sv | 27 ++
 rtl/uart_tx_sched.sv | 153 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: FSM state encoding, bit-period helper, default clock/baud.
// No datapath here; UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_pkg;

    localparam int DEF_MHZ  = 125;
    localparam int DEF_BAUD = 115200;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;
`endif

    // Clocks per serial bit, truncated.
    function automatic int clk_baud(input int mhz, input int baud);
        return (mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: o_tick high for one cycle when the count reaches CLK_BAUD-1, then wraps.
// Latency 0 (o_tick is decoded from the count); i_clr holds the count at zero, no backpressure.
module uart_baud_tick #(
    parameter int CLK_BAUD = 1085
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (CLK_BAUD > 1) ? $clog2(CLK_BAUD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_BAUD - 1);

    logic [CW-1:0] cnt;

    assign o_tick = !i_clr && (cnt == CNT_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr || o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one UART transmitter; grant pulses one cycle after i_req is seen in IDLE.
// No backpressure: requesters hold i_req until o_gnt; UART_TX_PARITY_EN inserts an even-parity bit.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int Mhz       = DEF_MHZ,
    parameter int Baud_Rate = DEF_BAUD,
    parameter int N_REQ     = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_req,
    input  logic [8*N_REQ-1:0] i_data,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [2:0]         o_gnt_id,
    output logic               o_busy,
    output logic               o_tx
);

    localparam int CLK_BAUD = clk_baud(Mhz, Baud_Rate);

    tx_state_t  state;
    logic [7:0] shreg;
    logic [2:0] bit_idx;
    logic [2:0] rr_ptr;
    logic       tick;
    logic       baud_clr;
`ifdef UART_TX_PARITY_EN
    logic       par;
`endif

    // Counter is parked in IDLE and restarted during the grant cycle so the start bit is a full period.
    assign baud_clr = (state == ST_IDLE) || (o_gnt != '0);

    uart_baud_tick #(
        .CLK_BAUD (CLK_BAUD)
    ) u_baud (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (baud_clr),
        .o_tick (tick)
    );

    logic [7:0]  req_ext;
    logic [63:0] data_ext;
    logic [3:0]  cand;
    logic [2:0]  pick_id;
    logic        pick_vld;
    logic [7:0]  pick_byte;

    assign req_ext   = 8'(i_req);
    assign data_ext  = 64'(i_data);
    assign pick_byte = data_ext[{pick_id, 3'b000} +: 8];

    // Round-robin search starting at rr_ptr and wrapping at N_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        cand     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr} + 4'(i);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (!pick_vld && req_ext[cand[2:0]]) begin
                pick_vld = 1'b1;
                pick_id  = cand[2:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            o_tx     <= 1'b1;
            o_busy   <= 1'b0;
            o_gnt    <= '0;
            o_gnt_id <= '0;
            rr_ptr   <= '0;
            shreg    <= '0;
            bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            o_gnt <= '0;
            case (state)
                ST_IDLE: begin
                    o_tx   <= 1'b1;
                    o_busy <= 1'b0;
                    if (pick_vld) begin
                        state    <= ST_START;
                        o_gnt    <= N_REQ'(1) << pick_id;
                        o_gnt_id <= pick_id;
                        o_busy   <= 1'b1;
                        shreg    <= pick_byte;
                        rr_ptr   <= (pick_id == 3'(N_REQ - 1)) ? 3'd0 : pick_id + 3'd1;
`ifdef UART_TX_PARITY_EN
                        par      <= ^pick_byte;
`endif
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= ST_DATA;
                        o_tx    <= shreg[0];
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= '0;
                    end else begin
                        o_tx <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= ST_PARITY;
                            o_tx  <= par;
`else
                            state <= ST_STOP;
                            o_tx  <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            o_tx    <= shreg[0];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                        o_tx  <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    o_tx <= 1'b1;
                    if (tick) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    o_tx  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched at CLK_BAUD=10 (1 MHz, 100 kbaud); honours UART_TX_PARITY_EN.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_uart_tx_sched;

    localparam int N = 4;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req;
    logic [8*N-1:0] i_data;
    logic [N-1:0]   o_gnt;
    logic [2:0]     o_gnt_id;
    logic           o_busy;
    logic           o_tx;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_sched #(
        .Mhz       (1),
        .Baud_Rate (100000),
        .N_REQ     (N)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (i_req),
        .i_data   (i_data),
        .o_gnt    (o_gnt),
        .o_gnt_id (o_gnt_id),
        .o_busy   (o_busy),
        .o_tx     (o_tx)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for a grant; n = falling edges waited.
    task automatic wait_gnt(input string tag, output int n);
        n = 0;
        while (o_gnt == '0 && n < 400) begin
            @(negedge i_clk);
            n++;
        end
        chk({tag, " gnt_seen"}, 32'(o_gnt != '0), 32'd1);
    endtask

    // Called at the grant-cycle falling edge; returns at the idle-cycle falling edge after the stop bit.
    task automatic run_frame(input string tag, input logic [7:0] b, input logic [7:0] alt, input int id);
        logic [10:0] exp_bits;
        int          nb;
        int          busy_n;
        exp_bits    = '1;
        exp_bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) exp_bits[k+1] = b[k];
`ifdef UART_TX_PARITY_EN
        exp_bits[9] = ^b;
        nb = 11;
`else
        nb = 10;
`endif
        chk({tag, " gnt"}, 32'(o_gnt), 32'(1) << id);
        chk({tag, " gnt_id"}, 32'(o_gnt_id), 32'(id));
        chk({tag, " tx_in_gnt"}, 32'(o_tx), 32'd1);
        busy_n = 0;
        for (int c = 0; c <= nb * 10; c++) begin
            if (o_busy) busy_n++;
            if (c == 1) chk({tag, " gnt_pulse"}, 32'(o_gnt), 32'd0);
            if (c == 30) i_data[8*id +: 8] = alt;
            if (c >= 6 && (c - 6) % 10 == 0)
                chk($sformatf("%s bit%0d", tag, (c - 6) / 10), 32'(o_tx), 32'(exp_bits[(c-6)/10]));
            @(negedge i_clk);
        end
        chk({tag, " busy_len"}, 32'(busy_n), 32'(nb * 10 + 1));
        chk({tag, " idle_busy"}, 32'(o_busy), 32'd0);
        chk({tag, " idle_tx"}, 32'(o_tx), 32'd1);
        chk({tag, " id_hold"}, 32'(o_gnt_id), 32'(id));
        i_data[8*id +: 8] = b;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    int n;
    logic [7:0] rr_byte [4] = '{8'h07, 8'h03, 8'hA5, 8'h3C};

    initial begin
        i_rst  = 1'b1;
        i_req  = '0;
        i_data = '0;
        @(negedge i_clk);
        do_reset();
        chk("rst tx", 32'(o_tx), 32'd1);
        chk("rst busy", 32'(o_busy), 32'd0);
        chk("rst gnt", 32'(o_gnt), 32'd0);
        chk("rst gnt_id", 32'(o_gnt_id), 32'd0);

        // Single request, byte 0x55
        i_data[7:0] = 8'h55;
        i_req       = 4'b0001;
        wait_gnt("single", n);
        chk("single latency", 32'(n), 32'd1);
        i_req = '0;
        run_frame("single", 8'h55, 8'hAA, 0);
        repeat (20) @(negedge i_clk);
        chk("no_req gnt", 32'(o_gnt), 32'd0);
        chk("no_req busy", 32'(o_busy), 32'd0);

        // Round robin with all requesters pending, starting from reset pointer
        do_reset();
        for (int k = 0; k < 4; k++) i_data[8*k +: 8] = rr_byte[k];
        i_req = 4'b1111;
        wait_gnt("rr first", n);
        run_frame("rr0", rr_byte[0], 8'hFF, 0);
        for (int k = 1; k <= 4; k++) begin
            wait_gnt($sformatf("rr%0d", k), n);
            chk($sformatf("rr%0d spacing", k), 32'(n), 32'd1);
            run_frame($sformatf("rr%0d", k), rr_byte[k % 4], 8'h00, k % 4);
        end

        // Pointer wrap: last grant 0, so 2 is granted first, then 0 before 2 again
        i_req = 4'b0100;
        wait_gnt("wrap a", n);
        i_req = 4'b0101;
        run_frame("wrap a", rr_byte[2], 8'h5A, 2);
        wait_gnt("wrap b", n);
        run_frame("wrap b", rr_byte[0], 8'hC3, 0);
        wait_gnt("wrap c", n);
        i_req = '0;
        run_frame("wrap c", rr_byte[2], 8'h81, 2);

        // Reset during DATA bit 3 of a frame to requester 0
        i_data[7:0] = 8'h96;
        i_req       = 4'b0001;
        wait_gnt("abort", n);
        i_req = 4'b0011;
        repeat (45) @(negedge i_clk);
        chk("abort bit3", 32'(o_tx), 32'(1'b0));
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("abort tx", 32'(o_tx), 32'd1);
        chk("abort busy", 32'(o_busy), 32'd0);
        chk("abort gnt", 32'(o_gnt), 32'd0);
        i_rst = 1'b0;
        wait_gnt("after abort", n);
        i_req = '0;
        run_frame("after abort", 8'h96, 8'h69, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
